// File: rtl/redn_pkg.sv
// rtl/redn_pkg.sv - shared types and elaboration helpers for reduce_pipe_n
package redn_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   // Pad bit that leaves a group result unchanged: 1 for AND-like ops, 0 otherwise
   function automatic logic identity(op_e op);
      return (op == OP_AND) || (op == OP_NAND);
   endfunction

   // Width of the vector entering tree level k
   function automatic int stage_width(int width, int radix, int k);
      int w;
      w = width;
      for (int i = 0; i < k; i++) begin
         w = (w + radix - 1) / radix;
      end
      return w;
   endfunction

   // Number of tree levels; a single bit still gets one register level
   function automatic int redn_stages(int width, int radix);
      int w;
      int s;
      w = width;
      s = 0;
      while (w > 1) begin
         w = (w + radix - 1) / radix;
         s++;
      end
      return (s < 1) ? 1 : s;
   endfunction

endpackage

// File: rtl/redn_stage.sv
// rtl/redn_stage.sv - one registered tree level (optional tag register under REDN_TAG_EN)
module redn_stage
   import redn_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int RADIX = 4,
   parameter int TAG_W = 4,
   localparam int OUT_W = (IN_W + RADIX - 1) / RADIX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   input  op_e              in_op,
   input  logic [IN_W-1:0]  in_data,
`ifdef REDN_TAG_EN
   input  logic [TAG_W-1:0] in_tag,
   output logic [TAG_W-1:0] out_tag,
`endif
   output logic             out_valid,
   output op_e              out_op,
   output logic [OUT_W-1:0] out_data
);

   localparam int PAD_W = OUT_W * RADIX;

   logic [PAD_W-1:0] padded;
   logic [OUT_W-1:0] red;

   // Pad the short last group with the identity bit, then reduce each RADIX-wide group
   always_comb begin
      padded = {PAD_W{identity(in_op)}};
      padded[IN_W-1:0] = in_data;
      red = '0;
      for (int g = 0; g < OUT_W; g++) begin
         red[g] = identity(in_op);
         for (int j = 0; j < RADIX; j++) begin
            case (in_op)
               OP_OR:   red[g] = red[g] | padded[g*RADIX+j];
               OP_XOR:  red[g] = red[g] ^ padded[g*RADIX+j];
               default: red[g] = red[g] & padded[g*RADIX+j];
            endcase
         end
      end
   end

   // Level register: shifts whenever the pipe advances, bubbles included
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_op    <= OP_AND;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_op    <= in_op;
         out_data  <= red;
      end
   end

`ifdef REDN_TAG_EN
   // Tag follows the valid bit with the same shift/hold behaviour
   always_ff @(posedge clk) begin
      if (reset) begin
         out_tag <= '0;
      end else if (en) begin
         out_tag <= in_tag;
      end
   end
`endif

endmodule

// File: rtl/reduce_pipe_n.sv
// rtl/reduce_pipe_n.sv - pipelined AND/OR/XOR/NAND reduction tree; tag sideband under REDN_TAG_EN
module reduce_pipe_n
   import redn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RADIX = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
`ifdef REDN_TAG_EN
   input  logic [TAG_W-1:0] in_tag,
   output logic [TAG_W-1:0] out_tag,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_y
);

   localparam int STAGES = redn_stages(WIDTH, RADIX);

   logic en;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : gen_stage
      localparam int IW = stage_width(WIDTH, RADIX, k);
      localparam int OW = stage_width(WIDTH, RADIX, k + 1);

      logic          vi;
      op_e           oi;
      logic [IW-1:0] di;
      logic          vo;
      op_e           oo;
      logic [OW-1:0] qo;
`ifdef REDN_TAG_EN
      logic [TAG_W-1:0] ti;
      logic [TAG_W-1:0] to;
`endif

      if (k == 0) begin : g_src
         assign vi = in_valid;
         assign oi = op_e'(in_op);
         assign di = in_data;
`ifdef REDN_TAG_EN
         assign ti = in_tag;
`endif
      end else begin : g_src
         assign vi = gen_stage[k-1].vo;
         assign oi = gen_stage[k-1].oo;
         assign di = gen_stage[k-1].qo;
`ifdef REDN_TAG_EN
         assign ti = gen_stage[k-1].to;
`endif
      end

      redn_stage #(
         .IN_W  (IW),
         .RADIX (RADIX),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .in_valid (vi),
         .in_op    (oi),
         .in_data  (di),
`ifdef REDN_TAG_EN
         .in_tag   (ti),
         .out_tag  (to),
`endif
         .out_valid(vo),
         .out_op   (oo),
         .out_data (qo)
      );
   end

   // NAND travels as AND through the tree and is inverted only here
   assign out_valid = gen_stage[STAGES-1].vo;
   assign out_y     = gen_stage[STAGES-1].qo[0] ^ (gen_stage[STAGES-1].oo == OP_NAND);
`ifdef REDN_TAG_EN
   assign out_tag   = gen_stage[STAGES-1].to;
`endif

endmodule

// File: tb/tb_reduce_pipe_n.sv
// tb/tb_reduce_pipe_n.sv - directed bench for reduce_pipe_n (8/4, 5/4 and 1/4 builds, tags under REDN_TAG_EN)
module tb_reduce_pipe_n;

   typedef struct {
      logic [7:0] data;
      logic [1:0] op;
      logic       y;
   } vec_t;

   typedef struct {
      logic       y;
      logic [3:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       v8 = 1'b0, r8, ov8, or8 = 1'b1, y8;
   logic [7:0] d8 = '0;
   logic [1:0] op8 = '0;
   logic       v5 = 1'b0, r5, ov5, or5 = 1'b1, y5;
   logic [4:0] d5 = '0;
   logic [1:0] op5 = '0;
   logic       v1 = 1'b0, r1, ov1, or1 = 1'b1, y1;
   logic [0:0] d1 = '0;
   logic [1:0] op1 = '0;
`ifdef REDN_TAG_EN
   logic [3:0] ti8 = '0, to8, ti5 = '0, to5, ti1 = '0, to1;
`endif

   int checks = 0;
   int errors = 0;
   vec_t tab[$];

   always #5 clk = ~clk;

   reduce_pipe_n #(.WIDTH(8), .RADIX(4), .TAG_W(4)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8), .in_data(d8), .in_op(op8),
`ifdef REDN_TAG_EN
      .in_tag(ti8), .out_tag(to8),
`endif
      .out_valid(ov8), .out_ready(or8), .out_y(y8));

   reduce_pipe_n #(.WIDTH(5), .RADIX(4), .TAG_W(4)) dut5 (
      .clk(clk), .reset(reset), .in_valid(v5), .in_ready(r5), .in_data(d5), .in_op(op5),
`ifdef REDN_TAG_EN
      .in_tag(ti5), .out_tag(to5),
`endif
      .out_valid(ov5), .out_ready(or5), .out_y(y5));

   reduce_pipe_n #(.WIDTH(1), .RADIX(4), .TAG_W(4)) dut1 (
      .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_op(op1),
`ifdef REDN_TAG_EN
      .in_tag(ti1), .out_tag(to1),
`endif
      .out_valid(ov1), .out_ready(or1), .out_y(y1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model(input logic [7:0] d, input logic [1:0] op);
      case (op)
         2'b00:   return &d;
         2'b01:   return |d;
         2'b10:   return ^d;
         default: return ~&d;
      endcase
   endfunction

   task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic [1:0] op,
                        input logic [3:0] tag);
      v8 = (sel == 8) && v; d8 = d;      op8 = op;
      v5 = (sel == 5) && v; d5 = d[4:0]; op5 = op;
      v1 = (sel == 1) && v; d1 = d[0];   op1 = op;
`ifdef REDN_TAG_EN
      ti8 = tag;
`else
      if (tag != 4'h0) d8 = d;
`endif
   endtask

   function automatic logic get_v(input int sel);
      return (sel == 8) ? ov8 : (sel == 5) ? ov5 : ov1;
   endfunction

   function automatic logic get_y(input int sel);
      return (sel == 8) ? y8 : (sel == 5) ? y5 : y1;
   endfunction

   // Back-to-back stream from tab, out_ready held high; word t shows up lat edges after it is presented
   task automatic run_table(input int sel);
      int lat;
      int n;
      lat = (sel == 1) ? 1 : 2;
      n = tab.size();
      for (int t = 0; t < n + lat; t++) begin
         if (t < n) drive(sel, 1'b1, tab[t].data, tab[t].op, 4'h0);
         else       drive(sel, 1'b0, 8'h00, 2'b00, 4'h0);
         @(posedge clk); #1;
         if (t >= lat - 1 && t - (lat - 1) < n) begin
            check($sformatf("w%0d_valid_%0d", sel, t - lat + 1), get_v(sel), 1);
            check($sformatf("w%0d_y_%0d", sel, t - lat + 1), get_y(sel), tab[t - lat + 1].y);
         end else if (t >= lat - 1) begin
            check($sformatf("w%0d_bubble", sel), get_v(sel), 0);
         end
      end
   endtask

   // Scoreboarded stream on dut8; mode 0 stalls cycles 2..6, mode 1 stalls randomly
   task automatic sb_run(input int mode, input int n);
      logic [7:0] wd[6] = '{8'hFF, 8'h00, 8'h07, 8'hFE, 8'h80, 8'h55};
      logic [1:0] wo[6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
      exp_t exp_q[$];
      exp_t e;
      int idx;
      int got;
      logic acc;
      idx = 0;
      got = 0;
      for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
         if (mode == 0) or8 = !(cyc >= 2 && cyc < 7);
         else           or8 = ($urandom_range(0, 2) != 0);
         if (idx < n) drive(8, 1'b1, wd[idx], wo[idx], 4'(idx + 1));
         else         drive(8, 1'b0, 8'h00, 2'b00, 4'h0);
         @(negedge clk);
         acc = v8 && r8;
         if (mode == 0 && cyc >= 2 && cyc < 7) begin
            check("bp_in_ready", r8, 0);
            check("bp_out_valid", ov8, 1);
            check("bp_out_y", y8, 1);
         end
         if (ov8 && or8) begin
            if (exp_q.size() == 0) begin
               check("sb_extra_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("sb%0d_y_%0d", mode, got), y8, e.y);
`ifdef REDN_TAG_EN
               check($sformatf("sb%0d_tag_%0d", mode, got), to8, e.tag);
`endif
               got++;
            end
         end
         if (acc) begin
            e.y = model(wd[idx], wo[idx]);
            e.tag = 4'(idx + 1);
            exp_q.push_back(e);
            idx++;
         end
         @(posedge clk); #1;
      end
      check($sformatf("sb%0d_count", mode), got, n);
      or8 = 1'b1;
      drive(8, 1'b0, 8'h00, 2'b00, 4'h0);
      @(posedge clk); #1;
      check($sformatf("sb%0d_drained", mode), ov8, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_ov8", ov8, 0); check("rst_y8", y8, 0); check("rst_rdy8", r8, 1);
      check("rst_ov5", ov5, 0); check("rst_rdy5", r5, 1);
      check("rst_ov1", ov1, 0); check("rst_y1", y1, 0);
`ifdef REDN_TAG_EN
      check("rst_tag8", to8, 0);
`endif

      tab.delete();
      tab.push_back('{8'hFF, 2'b00, 1'b1});
      tab.push_back('{8'hFE, 2'b00, 1'b0});
      tab.push_back('{8'hFE, 2'b11, 1'b1});
      tab.push_back('{8'h00, 2'b01, 1'b0});
      tab.push_back('{8'h10, 2'b01, 1'b1});
      tab.push_back('{8'h07, 2'b10, 1'b1});
      tab.push_back('{8'h03, 2'b10, 1'b0});
      tab.push_back('{8'hFF, 2'b11, 1'b0});
      run_table(8);

      tab.delete();
      tab.push_back('{8'h1F, 2'b00, 1'b1});
      tab.push_back('{8'h10, 2'b10, 1'b1});
      tab.push_back('{8'h00, 2'b01, 1'b0});
      tab.push_back('{8'h0F, 2'b00, 1'b0});
      tab.push_back('{8'h1F, 2'b10, 1'b1});
      tab.push_back('{8'h1E, 2'b11, 1'b1});
      run_table(5);

      tab.delete();
      tab.push_back('{8'h01, 2'b11, 1'b0});
      tab.push_back('{8'h01, 2'b00, 1'b1});
      tab.push_back('{8'h00, 2'b01, 1'b0});
      tab.push_back('{8'h01, 2'b10, 1'b1});
      tab.push_back('{8'h00, 2'b11, 1'b1});
      run_table(1);

      sb_run(0, 4);
      sb_run(1, 6);

      // Reset with two words in flight: nothing stale may emerge afterwards
      drive(8, 1'b1, 8'hFF, 2'b00, 4'h0);
      @(posedge clk); #1;
      drive(8, 1'b1, 8'h10, 2'b01, 4'h0);
      @(posedge clk); #1;
      drive(8, 1'b0, 8'h00, 2'b00, 4'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_ov", ov8, 0);
      check("mid_rst_rdy", r8, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("mid_rst_stale_%0d", i), ov8, 0);
      end
      drive(8, 1'b1, 8'hFE, 2'b11, 4'h0);
      @(posedge clk); #1;
      drive(8, 1'b0, 8'h00, 2'b00, 4'h0);
      check("post_rst_lat1", ov8, 0);
      @(posedge clk); #1;
      check("post_rst_lat2_v", ov8, 1);
      check("post_rst_lat2_y", y8, 1);
      @(posedge clk); #1;
      check("post_rst_drain", ov8, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reduce_pipe_n.md
Name: reduce_pipe_n

Overview:
- Parametrised, pipelined bitwise reduction unit. Generalises the combinational N-input AND to selectable AND/OR/XOR/NAND reduction.
- Built as a radix-R reduction tree with one register per tree level and a valid/ready handshake.
- Sits between a producer and consumer in the datapath and sustains one reduction per clock.

Parameters:
- WIDTH, 8, number of input bits to reduce (>=1).
- RADIX, 4, fan-in of each tree node per stage (>=2).
- TAG_W, 4, tag width carried alongside data (used only with REDN_TAG_EN).

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, unit accepts input this cycle.
- in_data, in, WIDTH, operand bits.
- in_op, in, 2, operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- in_tag, in, TAG_W, sideband tag (REDN_TAG_EN only).
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- out_y, out, 1, reduction result.
- out_tag, out, TAG_W, tag of result (REDN_TAG_EN only).

Behaviour:
- Clocking: one clock domain, clk. Reset is synchronous and active-high, named reset. All state updates on posedge clk.
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - out_y=0; out_tag=0; every stage data/op register=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Stage count: STAGES = max(1, ceil(log_RADIX(WIDTH))). Examples: WIDTH=8,RADIX=4 -> 2; WIDTH=16,RADIX=4 -> 2; WIDTH=1 -> 1.
- Stage k: splits its vector into groups of RADIX bits and reduces each group with the stage's op. The last group is padded with the identity element: 1 for AND/NAND, 0 for OR/XOR.
- op travels with data through every stage. NAND reduces as AND and inverts only at the final stage output.
- Advance rule: en = !out_valid || out_ready.
  - When en=1, every stage (bubbles included) shifts one step.
  - When en=0, all stages hold.
- in_ready = en (combinational). A transfer occurs when in_valid && in_ready.
- Stage-0 valid loads in_valid && en.
- Latency: accepted word appears on out_y/out_valid exactly STAGES cycles later when out_ready stays 1.
- Throughput: 1 word/cycle with out_ready=1.
- Backpressure:
  - out_valid=1 && out_ready=0 freezes the pipeline; out_y and out_tag hold stable.
  - No input is lost or duplicated.
- Bubbles: in_valid=0 inserts a bubble that propagates normally. out_valid falls to 0 when the bubble reaches the output.
- Simultaneous events: output consumed and new input accepted in the same cycle is legal and is the steady state.
- Reset mid-operation: all in-flight words are discarded. No output fires for them after reset.
- in_data/in_op are don't-care when in_valid=0. Stage data registers may load them, but valid stays 0.

Optional Feature:
- Macro: REDN_TAG_EN.
- Defined:
  - in_tag/out_tag ports exist.
  - The tag is registered alongside each stage's valid with identical shift/hold rules.
  - out_tag always pairs with its own result.
- Undefined:
  - in_tag/out_tag ports and tag registers are absent; TAG_W is unused.
  - All other behaviour is identical.

Decomposition:
- Package redn_pkg:
  - op_e enum (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11).
  - Function identity(op_e) returning the pad bit.
  - Function redn_stages(WIDTH,RADIX) computing STAGES.
  - Function stage_width(WIDTH,RADIX,k) giving the vector width entering stage k.
- Sub-module redn_stage:
  - One tree level: parameters IN_W and RADIX.
  - Combinational group reduce with padding, plus the valid/op/data (and optional tag) register with en.
- Top-level reduce_pipe_n: generate-loops STAGES instances and computes en/in_ready.

Test Plan:
- WIDTH=8, RADIX=4, out_ready=1:
  - in_data=8'hFF, op=AND -> out_y=1 after 2 cycles.
  - in_data=8'hFE, op=AND -> 0.
  - in_data=8'hFE, op=NAND -> 1.
- OR/XOR stream, back-to-back cycles:
  - in_data=8'h00, op=OR -> 0.
  - in_data=8'h10, op=OR -> 1.
  - in_data=8'h07, op=XOR -> 1.
  - in_data=8'h03, op=XOR -> 0.
  - Results appear in order on consecutive cycles, 1/cycle.
- Padding, WIDTH=5, RADIX=4 (STAGES=2):
  - in_data=5'h1F, op=AND -> 1.
  - in_data=5'h10, op=XOR -> 1.
  - in_data=5'h00, op=OR -> 0.
- Backpressure:
  - Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0; out_y/out_valid stable.
  - Release -> all words delivered in order, none dropped or repeated.
- Reset mid-stream:
  - Assert reset for 1 cycle with 2 words in flight -> out_valid=0 next cycle; no stale result ever appears.
  - A word accepted after reset emerges with latency 2.
- REDN_TAG_EN defined:
  - Tags 1,2,3 sent with mixed ops and random out_ready stalls -> out_tag matches each result's input tag.
- WIDTH=1: in_data=1, op=NAND -> out_y=0 after 1 cycle.
